h14tx_pll_ctrl: RTL and testbench

- Power-up and recovery sequencer for the HDMI TX PLL (serial/pixel clock generator) running on the 70 MHz reference clock.
- Drives PLL reset, waits for and qualifies lock, and bounds retries with timeouts.
- Holds the downstream TX datapath in reset until clocks are stable, and reacts to loss of lock at runtime.
- Sits between the top-level enable/reset and the PLL wrapper; tx_rst feeds the pixel/serial-domain reset synchronizers.

---
 rtl/h14tx_pll_ctrl.sv | 127 ++++++++++++
 tb/tb_h14tx_pll_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/h14tx_pll_ctrl.sv
// rtl/h14tx_pll_ctrl.sv - HDMI TX PLL power-up/recovery sequencer on the 70 MHz reference clock
// Optional lock-loss counter port enabled by defining H14TX_PLL_CTRL_LOSS_CNT_EN.
module h14tx_pll_ctrl #(
  parameter int RstCycles    = 64,
  parameter int LockTimeout  = 70000,
  parameter int StableCycles = 1024,
  parameter int MaxRetries   = 3,
  parameter int SyncStages   = 2,
  localparam int RetryW      = $clog2(MaxRetries + 1)
) (
  input  logic              ref_clk_70mhz,
  input  logic              rst,
  input  logic              enable,
  input  logic              pll_lock,
  output logic              pll_rst,
  output logic              tx_rst,
  output logic              ready,
  output logic              fault,
  output logic [RetryW-1:0] retry_cnt,
`ifdef H14TX_PLL_CTRL_LOSS_CNT_EN
  output logic [7:0]        lock_loss_cnt,
`endif
  output logic [2:0]        state
);

  localparam int CntMaxA = (RstCycles > LockTimeout) ? RstCycles : LockTimeout;
  localparam int CntMax  = (CntMaxA > StableCycles) ? CntMaxA : StableCycles;
  localparam int CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_READY     = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [SyncStages-1:0] sync_q;
  logic                  lock_s;
  logic [CntW-1:0]       cnt_q;
  logic [RetryW-1:0]     retry_q, retry_d, retry_inc;
  logic                  attempt_fail;
  logic                  loss_evt;

  assign lock_s    = sync_q[SyncStages-1];
  assign retry_cnt = retry_q;
  assign state     = state_q;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    retry_inc    = retry_q;
    attempt_fail = 1'b0;
    loss_evt     = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_RESET;
        S_RESET: if (cnt_q == CntW'(RstCycles - 1)) state_d = S_WAIT_LOCK;
        // A lock arriving on the timeout cycle wins over the timeout.
        S_WAIT_LOCK: begin
          if (lock_s) state_d = S_STABLE;
          else if (cnt_q == CntW'(LockTimeout - 1)) attempt_fail = 1'b1;
        end
        S_STABLE: begin
          if (!lock_s) attempt_fail = 1'b1;
          else if (cnt_q == CntW'(StableCycles - 1)) state_d = S_READY;
        end
        // Runtime loss of lock starts a fresh session, so retries are forgiven.
        S_READY: begin
          if (!lock_s) begin
            state_d  = S_RESET;
            retry_d  = '0;
            loss_evt = 1'b1;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
      if (attempt_fail) begin
        retry_inc = (retry_q == RetryW'(MaxRetries)) ? retry_q : retry_q + 1'b1;
        retry_d   = retry_inc;
        state_d   = (retry_inc == RetryW'(MaxRetries)) ? S_FAULT : S_RESET;
      end
    end
  end

  always_ff @(posedge ref_clk_70mhz) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      pll_rst <= 1'b1;
      tx_rst  <= 1'b1;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SyncStages-2:0], pll_lock};
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      retry_q <= retry_d;
      pll_rst <= (state_d == S_IDLE) || (state_d == S_RESET) || (state_d == S_FAULT);
      tx_rst  <= (state_d != S_READY);
      ready   <= (state_d == S_READY);
      fault   <= (state_d == S_FAULT);
    end
  end

`ifdef H14TX_PLL_CTRL_LOSS_CNT_EN
  always_ff @(posedge ref_clk_70mhz) begin
    if (rst) begin
      lock_loss_cnt <= '0;
    end else if (loss_evt && (lock_loss_cnt != 8'hff)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`else
  logic unused_loss;
  assign unused_loss = loss_evt;
`endif

endmodule

// File: tb/tb_h14tx_pll_ctrl.sv
// tb/tb_h14tx_pll_ctrl.sv - self-checking bench for h14tx_pll_ctrl
// Define H14TX_PLL_CTRL_LOSS_CNT_EN to also cover the lock-loss counter.
module tb_h14tx_pll_ctrl;
  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int ST_C  = 8;
  localparam int MR_C  = 3;
  localparam int SS_C  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_rst, tx_rst, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;
`ifdef H14TX_PLL_CTRL_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  always #7 clk = ~clk;

  h14tx_pll_ctrl #(
    .RstCycles(RST_C), .LockTimeout(TO_C), .StableCycles(ST_C),
    .MaxRetries(MR_C), .SyncStages(SS_C)
  ) dut (
    .ref_clk_70mhz(clk),
    .rst(rst),
    .enable(enable),
    .pll_lock(pll_lock),
    .pll_rst(pll_rst),
    .tx_rst(tx_rst),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
`ifdef H14TX_PLL_CTRL_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .state(state)
  );

  int total = 0;
  int bad = 0;

  // Reference: phase number, time spent in phase, and a lock history line.
  int m_phase = 0;
  int m_t = 0;
  int m_retry = 0;
  int m_loss = 0;
  bit m_hist[SS_C];

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_edge(input bit r, input bit e, input bit l);
    int nxt;
    bit ls;
    bit fail;
    if (r) begin
      m_phase = 0; m_t = 0; m_retry = 0; m_loss = 0;
      for (int i = 0; i < SS_C; i++) m_hist[i] = 1'b0;
      return;
    end
    ls = m_hist[SS_C-1];
    for (int i = SS_C - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = l;
    nxt = m_phase;
    fail = 1'b0;
    if (!e) begin
      nxt = 0; m_retry = 0;
    end else if (m_phase == 0) nxt = 1;
    else if (m_phase == 1) begin
      if (m_t + 1 >= RST_C) nxt = 2;
    end else if (m_phase == 2) begin
      if (ls) nxt = 3;
      else if (m_t + 1 >= TO_C) fail = 1'b1;
    end else if (m_phase == 3) begin
      if (!ls) fail = 1'b1;
      else if (m_t + 1 >= ST_C) nxt = 4;
    end else if (m_phase == 4) begin
      if (!ls) begin
        nxt = 1; m_retry = 0;
        if (m_loss < 255) m_loss++;
      end
    end
    if (fail) begin
      m_retry = (m_retry < MR_C) ? m_retry + 1 : MR_C;
      nxt = (m_retry >= MR_C) ? 5 : 1;
    end
    m_t = (nxt == m_phase) ? m_t + 1 : 0;
    m_phase = nxt;
  endfunction

  function automatic int act_vec();
    return int'({state, pll_rst, tx_rst, ready, fault, retry_cnt});
  endfunction

  function automatic int pack_exp(input int st, input bit pr, input bit rd, input bit fl, input int rt);
    return (st << 6) | (int'(pr) << 5) | (int'(!rd) << 4) | (int'(rd) << 3) | (int'(fl) << 2) | rt;
  endfunction

  task automatic step(input bit r, input bit e, input bit l);
    rst = r; enable = e; pll_lock = l;
    @(posedge clk);
    #1;
    model_edge(r, e, l);
    check("model", act_vec(),
          pack_exp(m_phase, (m_phase == 0) || (m_phase == 1) || (m_phase == 5),
                   m_phase == 4, m_phase == 5, m_retry));
`ifdef H14TX_PLL_CTRL_LOSS_CNT_EN
    check("model_loss", int'(lock_loss_cnt), m_loss);
`endif
  endtask

  typedef struct {
    bit r; bit e; bit l; int n;
    int st; int rt; bit rd; bit fl; bit pr;
  } seg_t;

  seg_t tbl[14];

  initial begin
    int first_low, first_rdy, relapse, n_hi, found;
    bit pr_h[41];
    bit rd_h[41];
    bit en_r, lk_r;
    int en_hold, lk_hold;

    tbl[0]  = '{1, 0, 0, 2,  0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 0, 1,  1, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 0, 4,  2, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 20, 1, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 24, 1, 2, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, 24, 5, 3, 0, 1, 1};
    tbl[6]  = '{0, 1, 0, 10, 5, 3, 0, 1, 1};
    tbl[7]  = '{0, 0, 0, 1,  0, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 1, 1,  1, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 1, 4,  2, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 1,  3, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 8,  4, 0, 1, 0, 0};
    tbl[12] = '{0, 1, 1, 5,  4, 0, 1, 0, 0};
    tbl[13] = '{1, 1, 1, 1,  0, 0, 0, 0, 1};

    for (int s = 0; s < 14; s++) begin
      for (int c = 0; c < tbl[s].n; c++) step(tbl[s].r, tbl[s].e, tbl[s].l);
      check($sformatf("seg%0d", s), act_vec(),
            pack_exp(tbl[s].st, tbl[s].pr, tbl[s].rd, tbl[s].fl, tbl[s].rt));
    end

    // Power-up latency with lock arriving as pll_rst is released.
    step(1, 0, 0);
    first_low = -1; first_rdy = -1; relapse = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 1, k >= 6);
      if (first_low < 0 && !pll_rst) first_low = k;
      if (first_rdy < 0 && ready) first_rdy = k;
      if (first_low >= 0 && pll_rst) relapse++;
    end
    check("pll_rst_fall", first_low, 5);
    check("ready_rise", first_rdy, 16);
    check("pll_rst_relapse", relapse, 0);
    check("tx_rst_ready", int'(tx_rst), 0);
    check("retry_after_up", int'(retry_cnt), 0);

    // One-cycle lock glitch while READY.
    for (int k = 1; k <= 40; k++) begin
      step(0, 1, k != 1);
      pr_h[k] = pll_rst; rd_h[k] = ready;
    end
    first_rdy = -1;
    for (int k = 1; k <= 40; k++) if (first_rdy < 0 && !rd_h[k]) first_rdy = k;
    check("glitch_ready_fall", first_rdy, 3);
    n_hi = 0;
    if (first_rdy > 0) for (int k = first_rdy; k <= 40 && pr_h[k]; k++) n_hi++;
    check("glitch_pll_rst_len", n_hi, 4);
    check("glitch_recover", int'(ready), 1);
    check("glitch_retry", int'(retry_cnt), 0);
`ifdef H14TX_PLL_CTRL_LOSS_CNT_EN
    check("glitch_loss_cnt", int'(lock_loss_cnt), 1);
`endif

    // Lock lost in STABLE at count 5.
    step(1, 0, 0); step(1, 0, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(0, 1, 1);
      if (state == 3'd3) found = 1;
    end
    check("reach_stable", found, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 1);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
    check("stable_drop_state", int'(state), 1);
    check("stable_drop_retry", int'(retry_cnt), 1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(0, 1, 1);
      if (ready) found = 1;
    end
    check("stable_drop_ready", found, 1);
    check("stable_drop_retry_held", int'(retry_cnt), 1);

    // rst mid WAIT_LOCK, then enable drop in STABLE.
    step(1, 0, 0);
    for (int k = 0; k < 32; k++) step(0, 1, 0);
    check("pre_rst_state", int'(state), 2);
    check("pre_rst_retry", int'(retry_cnt), 1);
    step(1, 1, 0);
    check("midrst", act_vec(), pack_exp(0, 1, 0, 0, 0));
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(0, 1, 1);
      if (state == 3'd3) found = 1;
    end
    check("reach_stable2", found, 1);
    step(0, 0, 1);
    check("en_drop_stable", act_vec(), pack_exp(0, 1, 0, 0, 0));

    // Lock on the timeout cycle versus one cycle late.
    for (int v = 0; v < 2; v++) begin
      step(1, 0, 0);
      for (int k = 0; k < 5; k++) step(0, 1, 0);
      check("wait_entry", int'(state), 2);
      for (int k = 0; k < 17 + v; k++) step(0, 1, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 1);
      check($sformatf("timeout_edge%0d_state", v), int'(state), v ? 1 : 3);
      check($sformatf("timeout_edge%0d_retry", v), int'(retry_cnt), v);
    end

`ifdef H14TX_PLL_CTRL_LOSS_CNT_EN
    step(1, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 1, 1);
    for (int n = 0; n < 300; n++) begin
      step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
        step(0, 1, 1);
        if (ready) found = 1;
      end
      if (!found) begin
        check("loss_loop_ready", found, 1);
        break;
      end
    end
    check("loss_sat", int'(lock_loss_cnt), 255);
    step(0, 0, 1);
    check("loss_kept_by_enable", int'(lock_loss_cnt), 255);
`endif

    // Randomized run-length stimulus against the reference.
    step(1, 0, 0);
    en_r = 1'b1; lk_r = 1'b0; en_hold = 0; lk_hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (lk_hold == 0) begin
        lk_r = ~lk_r;
        lk_hold = lk_r ? $urandom_range(40, 1) : $urandom_range(25, 1);
      end
      lk_hold--;
      if (en_hold == 0) begin
        en_r = ($urandom_range(99, 0) != 0);
        en_hold = en_r ? 1 : $urandom_range(5, 1);
      end
      en_hold--;
      step($urandom_range(299, 0) == 0, en_r, lk_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
